receptor: RTL and testbench



---
 rtl/receptor.sv | 130 +++++++++++++
 tb/tb_receptor.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/receptor.sv
// Serial receiver: 1 start, 8 data bits MSB first, odd parity, 1 stop, oversampled
// at CLKS_PER_BIT clocks per bit. The last good byte is held with a sticky valid flag.
module receptor #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       valid
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_q, par_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            sync1_q, rxs_q;

    // Two-flop synchronizer, preset to the idle-high line level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
        end else begin
            sync1_q <= rx;
            rxs_q   <= sync1_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        data_d  = data_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (!rxs_q) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == CNT_MID) begin
                    cnt_d = '0;
                    if (!rxs_q) begin
                        state_d = DATA;
                        idx_d   = '0;
                        valid_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    shift_d = {shift_q[6:0], rxs_q};
                    cnt_d   = '0;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == 3'd7) state_d = PARITY;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    par_d   = rxs_q;
                    cnt_d   = '0;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    // Odd parity: data bits plus parity bit must XOR to 1
                    if (rxs_q && ((^shift_q) ^ par_q)) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_out = data_q;
    assign valid    = valid_q;

endmodule

// File: tb/tb_receptor.sv
// Bench for receptor: directed and randomized frames checked against a frame-level
// model of which byte should be held and whether valid should be set.
module tb_receptor;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] data_out;
    logic       valid;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] m_data;
    logic       m_valid;

    always #5 clk = ~clk;

    receptor #(.CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .data_out (data_out),
        .valid    (valid)
    );

    // Frame bit order on the wire: [0]=start, [1..8]=data MSB first, [9]=parity, [10]=stop
    function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic p, input logic s);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1+i] = d[7-i];
        f[9]  = p;
        f[10] = s;
        return f;
    endfunction

    function automatic logic odd_par(input logic [7:0] d);
        return ~(^d);
    endfunction

    // Outcome of a complete frame whose start bit was confirmed
    task automatic model_frame(input logic [7:0] d, input logic p, input logic s);
        if (s && ((^d) ^ p)) begin
            m_data  = d;
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
    endtask

    // rx changes 1 time unit after a rising edge; each bit lasts CPB clocks
    task automatic send_bits(input logic [10:0] f, input int from, input int to);
        for (int i = from; i <= to; i++) begin
            rx = f[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_clks(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (valid !== 1'b0 || data_out !== 8'h00) begin
            miscompares++;
            $display("FAIL reset: valid=%b data_out=%02h, expected valid=0 data_out=00", valid, data_out);
        end
        rst = 1'b0;
        m_valid = 1'b0;
        m_data  = 8'h00;
        idle_clks(2);
    endtask

    task automatic test_idle;
        for (int k = 0; k < 10; k++) begin
            idle_clks(50);
            vectors++;
            if (valid !== 1'b0 || data_out !== 8'h00) begin
                miscompares++;
                $display("FAIL idle: valid=%b data_out=%02h, expected valid=0 data_out=00", valid, data_out);
            end
        end
        $display("idle 500 clocks: valid=%b data_out=%02h", valid, data_out);
    endtask

    task automatic test_good_frame;
        send_bits(mk_frame(8'hAA, 1'b1, 1'b1), 0, 10);
        model_frame(8'hAA, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            idle_clks(8);
            vectors++;
            if (valid !== m_valid || data_out !== m_data) begin
                miscompares++;
                $display("FAIL good_frame: valid=%b data_out=%02h, expected valid=%b data_out=%02h",
                         valid, data_out, m_valid, m_data);
            end
        end
        $display("frame AA p=1 s=1: valid=%b data_out=%02h", valid, data_out);
    endtask

    task automatic test_parity_error;
        send_bits(mk_frame(8'hAA, 1'b0, 1'b1), 0, 10);
        model_frame(8'hAA, 1'b0, 1'b1);
        idle_clks(32);
        vectors++;
        if (valid !== m_valid || data_out !== m_data) begin
            miscompares++;
            $display("FAIL parity_error: valid=%b data_out=%02h, expected valid=%b data_out=%02h",
                     valid, data_out, m_valid, m_data);
        end
        $display("frame AA p=0 s=1: valid=%b data_out=%02h", valid, data_out);
    endtask

    task automatic test_framing_error;
        send_bits(mk_frame(8'h0F, 1'b1, 1'b0), 0, 10);
        model_frame(8'h0F, 1'b1, 1'b0);
        idle_clks(32);
        vectors++;
        if (valid !== m_valid || data_out !== m_data) begin
            miscompares++;
            $display("FAIL framing_error: valid=%b data_out=%02h, expected valid=%b data_out=%02h",
                     valid, data_out, m_valid, m_data);
        end
        $display("frame 0F p=1 s=0: valid=%b data_out=%02h", valid, data_out);
    endtask

    task automatic test_glitch;
        send_bits(mk_frame(8'h3C, 1'b1, 1'b1), 0, 10);
        model_frame(8'h3C, 1'b1, 1'b1);
        idle_clks(16);
        rx = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        idle_clks(40);
        vectors++;
        if (valid !== m_valid || data_out !== m_data) begin
            miscompares++;
            $display("FAIL glitch: valid=%b data_out=%02h, expected valid=%b data_out=%02h",
                     valid, data_out, m_valid, m_data);
        end
        // A real frame right after must still be accepted
        send_bits(mk_frame(8'h5A, odd_par(8'h5A), 1'b1), 0, 10);
        model_frame(8'h5A, odd_par(8'h5A), 1'b1);
        vectors++;
        if (valid !== m_valid || data_out !== m_data) begin
            miscompares++;
            $display("FAIL glitch_recover: valid=%b data_out=%02h, expected valid=%b data_out=%02h",
                     valid, data_out, m_valid, m_data);
        end
        $display("glitch 5 clocks then 5A: valid=%b data_out=%02h", valid, data_out);
    endtask

    task automatic test_back_to_back;
        logic [10:0] f2;
        send_bits(mk_frame(8'hAA, 1'b1, 1'b1), 0, 10);
        model_frame(8'hAA, 1'b1, 1'b1);
        vectors++;
        if (valid !== 1'b1 || data_out !== 8'hAA) begin
            miscompares++;
            $display("FAIL b2b_first: valid=%b data_out=%02h, expected valid=1 data_out=aa", valid, data_out);
        end
        f2 = mk_frame(8'h01, 1'b0, 1'b1);
        send_bits(f2, 0, 2);
        vectors++;
        if (valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_valid_drop: valid=%b, expected 0", valid);
        end
        send_bits(f2, 3, 10);
        model_frame(8'h01, 1'b0, 1'b1);
        vectors++;
        if (valid !== m_valid || data_out !== m_data) begin
            miscompares++;
            $display("FAIL b2b_second: valid=%b data_out=%02h, expected valid=%b data_out=%02h",
                     valid, data_out, m_valid, m_data);
        end
        $display("back-to-back AA,01: valid=%b data_out=%02h", valid, data_out);
        idle_clks(16);
    endtask

    task automatic test_reset_mid_frame;
        send_bits(mk_frame(8'hC3, odd_par(8'hC3), 1'b1), 0, 4);
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (valid !== 1'b0 || data_out !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_mid_frame: valid=%b data_out=%02h, expected valid=0 data_out=00", valid, data_out);
        end
        m_valid = 1'b0;
        m_data  = 8'h00;
        rx = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle_clks(20);
        send_bits(mk_frame(8'hAA, 1'b1, 1'b1), 0, 10);
        model_frame(8'hAA, 1'b1, 1'b1);
        vectors++;
        if (valid !== m_valid || data_out !== m_data) begin
            miscompares++;
            $display("FAIL reset_recover: valid=%b data_out=%02h, expected valid=%b data_out=%02h",
                     valid, data_out, m_valid, m_data);
        end
        $display("reset mid-frame then AA: valid=%b data_out=%02h", valid, data_out);
        idle_clks(16);
    endtask

    task automatic test_random;
        logic [7:0] d;
        logic       p, s;
        int         gap;
        for (int n = 0; n < 30; n++) begin
            d = 8'($urandom);
            p = ($urandom_range(0, 3) != 0) ? odd_par(d) : ~odd_par(d);
            s = ($urandom_range(0, 4) != 0);
            send_bits(mk_frame(d, p, s), 0, 10);
            model_frame(d, p, s);
            vectors++;
            if (valid !== m_valid || data_out !== m_data) begin
                miscompares++;
                $display("FAIL random[%0d]: valid=%b data_out=%02h, expected valid=%b data_out=%02h",
                         n, valid, data_out, m_valid, m_data);
            end
            $display("random frame %02h p=%b s=%b: valid=%b data_out=%02h", d, p, s, valid, data_out);
            // A low stop bit is seen as a new start; give that false start time to be rejected
            gap = s ? int'($urandom_range(0, 20)) : 16 + int'($urandom_range(0, 8));
            if (gap > 0) idle_clks(gap);
        end
    endtask

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        m_valid = 1'b0;
        m_data  = 8'h00;
        test_reset;
        test_idle;
        test_good_frame;
        test_parity_error;
        test_framing_error;
        test_glitch;
        test_back_to_back;
        test_reset_mid_frame;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
